// File: rtl/sram_write_collector_q_if.sv
// Handshake and data bundle between the write collector and its neighbours:
// alloc/cmd/DRAM-line inputs, commit-queue head and SRAM write-beat outputs.
interface sram_write_collector_q_if #(
  parameter int unsigned LBW    = 16,
  parameter int unsigned DBW    = 32,
  parameter int unsigned VSIZE  = 8,
  parameter int unsigned CSIZE  = 8,
  parameter int unsigned N_ICFG = 4
);
  localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1);
  localparam int unsigned CV_BW   = $clog2(VSIZE);
  localparam int unsigned CV_BW1  = $clog2(VSIZE + 1);
  localparam int unsigned CC_BW   = $clog2(CSIZE);

  logic                     alloc_linear_rdy;
  logic                     alloc_linear_ack;
  logic [LBW-1:0]           i_linear;
  logic [ICFG_BW-1:0]       i_linear_id;
  logic [LBW:0]             i_size;
  logic                     i_skip;
  logic [DBW-1:0]           i_padv;
  logic                     cmd_rdy;
  logic                     cmd_ack;
  logic [1:0]               i_cmd_type;
  logic                     i_cmd_islast;
  logic [CC_BW-1:0]         i_cmd_addrofs;
  logic [CV_BW1-1:0]        i_cmd_len;
  logic                     dramrd_rdy;
  logic                     dramrd_ack;
  logic [DBW*CSIZE-1:0]     i_dramrd;
  logic                     done_linear_rdy;
  logic                     done_linear_ack;
  logic [LBW-1:0]           o_linear;
  logic [ICFG_BW-1:0]       o_linear_id;
  logic                     w_dval;
  logic [ICFG_BW-1:0]       o_id;
  logic [LBW-CV_BW-1:0]     o_hiaddr;
  logic [VSIZE-1:0]         o_wmask;
  logic [DBW*VSIZE-1:0]     o_data;

  modport master (
    output alloc_linear_rdy, i_linear, i_linear_id, i_size, i_skip, i_padv,
           cmd_rdy, i_cmd_type, i_cmd_islast, i_cmd_addrofs, i_cmd_len,
           dramrd_rdy, i_dramrd, done_linear_ack,
    input  alloc_linear_ack, cmd_ack, dramrd_ack, done_linear_rdy, o_linear,
           o_linear_id, w_dval, o_id, o_hiaddr, o_wmask, o_data
  );

  modport slave (
    input  alloc_linear_rdy, i_linear, i_linear_id, i_size, i_skip, i_padv,
           cmd_rdy, i_cmd_type, i_cmd_islast, i_cmd_addrofs, i_cmd_len,
           dramrd_rdy, i_dramrd, done_linear_ack,
    output alloc_linear_ack, cmd_ack, dramrd_ack, done_linear_rdy, o_linear,
           o_linear_id, w_dval, o_id, o_hiaddr, o_wmask, o_data
  );
endinterface

// File: rtl/sram_write_collector_q.sv
// Collects DRAM-line copy / broadcast / pad commands into masked VSIZE-wide
// SRAM write beats for one linear buffer, with an N_SLOT-deep commit queue.
module sram_write_collector_q #(
  parameter int unsigned LBW    = 16,
  parameter int unsigned DBW    = 32,
  parameter int unsigned VSIZE  = 8,
  parameter int unsigned CSIZE  = 8,
  parameter int unsigned N_ICFG = 4,
  parameter int unsigned N_SLOT = 2
) (
  input logic                     i_clk,
  input logic                     i_rst,
  sram_write_collector_q_if.slave bus
);
  localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1);
  localparam int unsigned CV_BW   = $clog2(VSIZE);
  localparam int unsigned CV_BW1  = $clog2(VSIZE + 1);
  localparam int unsigned CC_BW   = $clog2(CSIZE);
  localparam int unsigned HA_BW   = LBW - CV_BW;
  localparam int unsigned QP_BW   = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int unsigned QC_BW   = $clog2(N_SLOT + 1);

  typedef enum logic {FREE, RUN} state_e;

  state_e                        state_q, state_d;
  logic [LBW-1:0]                lin_q, lin_d, cur_q, cur_d;
  logic [ICFG_BW-1:0]            id_q, id_d;
  logic [LBW:0]                  size_q, size_d, filled_q, filled_d;
  logic [DBW-1:0]                padv_q, padv_d;
  logic [CV_BW1-1:0]             handled_q, handled_d;
  logic [VSIZE-1:0]              mask_acc_q, mask_acc_d;
  logic [VSIZE-1:0][DBW-1:0]     data_q, data_d;
  logic                          w_dval_q, w_dval_d;
  logic [VSIZE-1:0]              o_wmask_q, o_wmask_d;
  logic [HA_BW-1:0]              o_hiaddr_q, o_hiaddr_d;
  logic [ICFG_BW-1:0]            o_id_q, o_id_d;
  logic [LBW-1:0]                q_lin_q [N_SLOT];
  logic [LBW-1:0]                q_lin_d [N_SLOT];
  logic [ICFG_BW-1:0]            q_id_q [N_SLOT];
  logic [ICFG_BW-1:0]            q_id_d [N_SLOT];
  logic [QP_BW-1:0]              wr_q, wr_d, rd_q, rd_d;
  logic [QC_BW-1:0]              cnt_q, cnt_d;

  logic [CSIZE-1:0][DBW-1:0]     line_c;
  logic [CV_BW-1:0]              lane_c;
  logic [CV_BW1-1:0]             buf_left_c, cmd_left_c, adv_c, jj_c;
  logic [CC_BW-1:0]              bidx_c, widx_c;
  logic [QC_BW:0]                reserved_c;
  logic [VSIZE-1:0]              mask_step_c, mask_new_c;
  logic [LBW:0]                  filled_nxt_c;
  logic                          alloc_ack_c, cmd_ack_c, dram_ack_c, step_c;
  logic                          push_c, pop_c, last_c;
  logic [LBW-1:0]                push_lin_c;
  logic [ICFG_BW-1:0]            push_id_c;

  assign line_c     = bus.i_dramrd;
  assign lane_c     = cur_q[CV_BW-1:0];
  assign buf_left_c = CV_BW1'(VSIZE) - CV_BW1'(lane_c);
  assign cmd_left_c = bus.i_cmd_len - handled_q;
  assign adv_c      = (cmd_left_c <= buf_left_c) ? cmd_left_c : buf_left_c;
  assign bidx_c     = CC_BW'(bus.i_cmd_addrofs + CC_BW'(handled_q));
  // An open RUN buffer holds a queue slot so its final push can never overflow.
  assign reserved_c = {1'b0, cnt_q} + (QC_BW+1)'(state_q == RUN);

  always_comb begin
    state_d      = state_q;
    lin_d        = lin_q;
    id_d         = id_q;
    size_d       = size_q;
    padv_d       = padv_q;
    cur_d        = cur_q;
    filled_d     = filled_q;
    handled_d    = handled_q;
    mask_acc_d   = mask_acc_q;
    data_d       = data_q;
    w_dval_d     = 1'b0;
    o_wmask_d    = '0;
    o_hiaddr_d   = o_hiaddr_q;
    o_id_d       = o_id_q;
    q_lin_d      = q_lin_q;
    q_id_d       = q_id_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    alloc_ack_c  = 1'b0;
    cmd_ack_c    = 1'b0;
    dram_ack_c   = 1'b0;
    step_c       = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    last_c       = 1'b0;
    push_lin_c   = lin_q;
    push_id_c    = id_q;
    mask_step_c  = '0;
    mask_new_c   = mask_acc_q;
    filled_nxt_c = filled_q + (LBW+1)'(adv_c);
    jj_c         = '0;
    widx_c       = '0;

    case (state_q)
      FREE: begin
        alloc_ack_c = bus.alloc_linear_rdy && (reserved_c < (QC_BW+1)'(N_SLOT));
        if (alloc_ack_c) begin
          lin_d      = bus.i_linear;
          id_d       = bus.i_linear_id;
          size_d     = bus.i_size;
          padv_d     = bus.i_padv;
          cur_d      = bus.i_linear;
          filled_d   = '0;
          handled_d  = '0;
          mask_acc_d = '0;
          if (bus.i_skip) begin
            push_c     = 1'b1;
            push_lin_c = bus.i_linear;
            push_id_c  = bus.i_linear_id;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        step_c = bus.cmd_rdy && ((bus.i_cmd_type[1] && !bus.i_cmd_islast) || bus.dramrd_rdy);
        if (step_c) begin
          for (int unsigned j = 0; j < VSIZE; j++) begin
            jj_c = CV_BW1'(j);
            if (jj_c >= CV_BW1'(lane_c) && jj_c < CV_BW1'(lane_c) + adv_c) begin
              mask_step_c[j] = 1'b1;
              widx_c = CC_BW'(bus.i_cmd_addrofs + CC_BW'(handled_q) +
                              CC_BW'(jj_c - CV_BW1'(lane_c)));
              case (bus.i_cmd_type)
                2'd0:    data_d[j] = line_c[widx_c];
                2'd1:    data_d[j] = line_c[bidx_c];
                default: data_d[j] = padv_q;
              endcase
            end
          end
          mask_new_c = mask_acc_q | mask_step_c;
          cur_d      = cur_q + LBW'(adv_c);
          filled_d   = filled_nxt_c;
          cmd_ack_c  = (cmd_left_c <= buf_left_c);
          handled_d  = cmd_ack_c ? '0 : handled_q + adv_c;
          dram_ack_c = cmd_ack_c && bus.i_cmd_islast && bus.dramrd_rdy;
          last_c     = (filled_nxt_c == size_q);
          // Beat goes out when the top lane is written or the buffer is complete.
          if ((CV_BW1'(lane_c) + adv_c == CV_BW1'(VSIZE)) || last_c) begin
            w_dval_d   = 1'b1;
            o_wmask_d  = mask_new_c;
            o_hiaddr_d = cur_q[LBW-1:CV_BW];
            o_id_d     = id_q;
            mask_acc_d = '0;
          end else begin
            mask_acc_d = mask_new_c;
          end
          if (last_c) begin
            push_c  = 1'b1;
            state_d = FREE;
          end
        end
      end
      default: state_d = FREE;
    endcase

    // Commit FIFO; a pop reads the head before a same-edge push can reuse its slot.
    pop_c = bus.done_linear_ack && (cnt_q != '0);
    if (push_c) begin
      q_lin_d[wr_q] = push_lin_c;
      q_id_d[wr_q]  = push_id_c;
      wr_d = (wr_q == QP_BW'(N_SLOT - 1)) ? '0 : wr_q + QP_BW'(1);
    end
    if (pop_c) begin
      rd_d = (rd_q == QP_BW'(N_SLOT - 1)) ? '0 : rd_q + QP_BW'(1);
    end
    cnt_d = cnt_q + QC_BW'(push_c) - QC_BW'(pop_c);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= FREE;
      lin_q      <= '0;
      id_q       <= '0;
      size_q     <= '0;
      padv_q     <= '0;
      cur_q      <= '0;
      filled_q   <= '0;
      handled_q  <= '0;
      mask_acc_q <= '0;
      data_q     <= '0;
      w_dval_q   <= 1'b0;
      o_wmask_q  <= '0;
      o_hiaddr_q <= '0;
      o_id_q     <= '0;
      q_lin_q    <= '{default: '0};
      q_id_q     <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lin_q      <= lin_d;
      id_q       <= id_d;
      size_q     <= size_d;
      padv_q     <= padv_d;
      cur_q      <= cur_d;
      filled_q   <= filled_d;
      handled_q  <= handled_d;
      mask_acc_q <= mask_acc_d;
      data_q     <= data_d;
      w_dval_q   <= w_dval_d;
      o_wmask_q  <= o_wmask_d;
      o_hiaddr_q <= o_hiaddr_d;
      o_id_q     <= o_id_d;
      q_lin_q    <= q_lin_d;
      q_id_q     <= q_id_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  // Handshake acks are gated by reset so none can fire while it is held.
  assign bus.alloc_linear_ack = alloc_ack_c & i_rst;
  assign bus.cmd_ack          = cmd_ack_c & i_rst;
  assign bus.dramrd_ack       = dram_ack_c & i_rst;
  assign bus.done_linear_rdy  = (cnt_q != '0);
  assign bus.o_linear         = q_lin_q[rd_q];
  assign bus.o_linear_id      = q_id_q[rd_q];
  assign bus.w_dval           = w_dval_q;
  assign bus.o_id             = o_id_q;
  assign bus.o_hiaddr         = o_hiaddr_q;
  assign bus.o_wmask          = o_wmask_q;
  assign bus.o_data           = data_q;
endmodule

// File: tb/tb_sram_write_collector_q.sv
// Directed bench for sram_write_collector_q: aligned/unaligned copies, pad and
// broadcast, commit-queue backpressure, skip allocs and reset in mid-buffer.
module tb_sram_write_collector_q;
  localparam int unsigned LBW     = 16;
  localparam int unsigned DBW     = 32;
  localparam int unsigned VSIZE   = 8;
  localparam int unsigned CSIZE   = 8;
  localparam int unsigned N_ICFG  = 4;
  localparam int unsigned N_SLOT  = 2;
  localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1);
  localparam int unsigned CV_BW   = $clog2(VSIZE);
  localparam int unsigned CV_BW1  = $clog2(VSIZE + 1);
  localparam int unsigned CC_BW   = $clog2(CSIZE);
  localparam int unsigned HA_BW   = LBW - CV_BW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_write_collector_q_if #(.LBW(LBW), .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE),
                              .N_ICFG(N_ICFG)) bus ();

  sram_write_collector_q #(.LBW(LBW), .DBW(DBW), .VSIZE(VSIZE), .CSIZE(CSIZE),
                           .N_ICFG(N_ICFG), .N_SLOT(N_SLOT)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [HA_BW-1:0]       mon_hi   [64];
  logic [VSIZE-1:0]       mon_mask [64];
  logic [DBW*VSIZE-1:0]   mon_data [64];
  logic [ICFG_BW-1:0]     mon_id   [64];
  int unsigned beat_n    = 0;
  int unsigned cmd_acks  = 0;
  int unsigned dram_acks = 0;

  always @(negedge clk) begin
    if (bus.w_dval) begin
      if (beat_n < 64) begin
        mon_hi[beat_n]   = bus.o_hiaddr;
        mon_mask[beat_n] = bus.o_wmask;
        mon_data[beat_n] = bus.o_data;
        mon_id[beat_n]   = bus.o_id;
      end
      beat_n++;
    end
    if (bus.cmd_ack)    cmd_acks++;
    if (bus.dramrd_ack) dram_acks++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic logic [DBW*CSIZE-1:0] mk_line(input logic [DBW-1:0] base);
    logic [DBW*CSIZE-1:0] l;
    for (int i = 0; i < CSIZE; i++) l[i*DBW +: DBW] = base + DBW'(i);
    return l;
  endfunction

  function automatic logic [DBW*VSIZE-1:0] lanes(input logic [VSIZE-1:0] m);
    logic [DBW*VSIZE-1:0] r;
    for (int i = 0; i < VSIZE; i++) r[i*DBW +: DBW] = {DBW{m[i]}};
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc_linear_rdy = 1'b0;
    bus.i_linear         = '0;
    bus.i_linear_id      = '0;
    bus.i_size           = '0;
    bus.i_skip           = 1'b0;
    bus.i_padv           = '0;
    bus.cmd_rdy          = 1'b0;
    bus.i_cmd_type       = '0;
    bus.i_cmd_islast     = 1'b0;
    bus.i_cmd_addrofs    = '0;
    bus.i_cmd_len        = '0;
    bus.dramrd_rdy       = 1'b0;
    bus.i_dramrd         = '0;
    bus.done_linear_ack  = 1'b0;
  endtask

  task automatic do_alloc(input logic [LBW-1:0] lin, input logic [ICFG_BW-1:0] id,
                          input logic [LBW:0] size, input logic skip,
                          input logic [DBW-1:0] padv, output bit ok);
    bus.i_linear = lin; bus.i_linear_id = id; bus.i_size = size;
    bus.i_skip = skip; bus.i_padv = padv; bus.alloc_linear_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = bus.alloc_linear_ack;
    end
    @(posedge clk); #1;
    bus.alloc_linear_rdy = 1'b0;
    bus.i_skip = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] typ, input logic last,
                          input logic [CC_BW-1:0] ofs, input logic [CV_BW1-1:0] len,
                          input logic dv, input logic [DBW*CSIZE-1:0] ln, output bit ok);
    bus.i_cmd_type = typ; bus.i_cmd_islast = last; bus.i_cmd_addrofs = ofs;
    bus.i_cmd_len = len; bus.i_dramrd = ln; bus.dramrd_rdy = dv; bus.cmd_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ack;
    end
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
    bus.dramrd_rdy = 1'b0;
  endtask

  task automatic pop_head();
    bus.done_linear_ack = 1'b1;
    @(posedge clk); #1;
    bus.done_linear_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.alloc_linear_rdy = 1'b1; bus.cmd_rdy = 1'b1; bus.dramrd_rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    n_total++; if ({bus.w_dval, bus.done_linear_rdy, bus.alloc_linear_ack, bus.cmd_ack, bus.dramrd_ack} !== 5'b0)
      $display("FAIL rst_flags got %b exp 00000", {bus.w_dval, bus.done_linear_rdy, bus.alloc_linear_ack, bus.cmd_ack, bus.dramrd_ack}); else n_pass++;
    n_total++; if (bus.o_wmask !== '0) $display("FAIL rst_wmask got %h exp 0", bus.o_wmask); else n_pass++;
    n_total++; if (bus.o_data !== '0) $display("FAIL rst_data got %h exp 0", bus.o_data); else n_pass++;
    n_total++; if ({bus.o_hiaddr, bus.o_id} !== '0) $display("FAIL rst_hiaddr_id got %h exp 0", {bus.o_hiaddr, bus.o_id}); else n_pass++;
    n_total++; if ({bus.o_linear, bus.o_linear_id} !== '0) $display("FAIL rst_linear got %h exp 0", {bus.o_linear, bus.o_linear_id}); else n_pass++;
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_aligned();
    bit ok;
    int unsigned b0 = beat_n;
    logic [DBW*CSIZE-1:0] ln = mk_line(32'h1000_0000);
    do_alloc(16'h0010, 3'd1, 17'd8, 1'b0, '0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t1_alloc_ack got %b exp 1", ok); else n_pass++;
    send_cmd(2'd0, 1'b1, 3'd0, 4'd8, 1'b1, ln, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t1_cmd_ack got %b exp 1", ok); else n_pass++;
    tick(2);
    n_total++; if (beat_n - b0 != 1) $display("FAIL t1_beats got %0d exp 1", beat_n - b0); else n_pass++;
    n_total++; if (mon_hi[b0] !== 13'd2) $display("FAIL t1_hiaddr got %h exp 2", mon_hi[b0]); else n_pass++;
    n_total++; if (mon_mask[b0] !== 8'hFF) $display("FAIL t1_wmask got %h exp ff", mon_mask[b0]); else n_pass++;
    n_total++; if (mon_data[b0] !== ln) $display("FAIL t1_data got %h exp %h", mon_data[b0], ln); else n_pass++;
    n_total++; if (mon_id[b0] !== 3'd1) $display("FAIL t1_id got %0d exp 1", mon_id[b0]); else n_pass++;
    n_total++; if ({bus.done_linear_rdy, bus.o_linear, bus.o_linear_id} !== {1'b1, 16'h0010, 3'd1})
      $display("FAIL t1_commit got %b/%h/%0d exp 1/0010/1", bus.done_linear_rdy, bus.o_linear, bus.o_linear_id); else n_pass++;
    pop_head();
    n_total++; if (bus.done_linear_rdy !== 1'b0) $display("FAIL t1_pop got %b exp 0", bus.done_linear_rdy); else n_pass++;
  endtask

  task automatic test_unaligned();
    bit ok;
    int unsigned b0 = beat_n, c0 = cmd_acks, d0 = dram_acks;
    logic [DBW-1:0] base = 32'h2000_0000;
    logic [DBW*CSIZE-1:0] ln = mk_line(base);
    logic [DBW*VSIZE-1:0] e1 = '0, e2 = '0;
    for (int j = 3; j < 8; j++) e1[j*DBW +: DBW] = base + DBW'(j - 1);
    e2[0 +: DBW] = base + 32'd7;
    e2[DBW +: DBW] = base;
    e2[2*DBW +: DBW] = base + 32'd1;
    do_alloc(16'h0013, 3'd2, 17'd8, 1'b0, '0, ok);
    send_cmd(2'd0, 1'b1, 3'd2, 4'd8, 1'b1, ln, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t2_cmd_ack got %b exp 1", ok); else n_pass++;
    tick(2);
    n_total++; if (beat_n - b0 != 2) $display("FAIL t2_beats got %0d exp 2", beat_n - b0); else n_pass++;
    n_total++; if ({mon_hi[b0], mon_mask[b0]} !== {13'd2, 8'hF8})
      $display("FAIL t2_beat1 got %h/%h exp 2/f8", mon_hi[b0], mon_mask[b0]); else n_pass++;
    n_total++; if ((mon_data[b0] & lanes(8'hF8)) !== e1) $display("FAIL t2_data1 got %h exp %h", mon_data[b0] & lanes(8'hF8), e1); else n_pass++;
    n_total++; if ({mon_hi[b0+1], mon_mask[b0+1]} !== {13'd3, 8'h07})
      $display("FAIL t2_beat2 got %h/%h exp 3/07", mon_hi[b0+1], mon_mask[b0+1]); else n_pass++;
    n_total++; if ((mon_data[b0+1] & lanes(8'h07)) !== e2) $display("FAIL t2_data2 got %h exp %h", mon_data[b0+1] & lanes(8'h07), e2); else n_pass++;
    n_total++; if (cmd_acks - c0 != 1) $display("FAIL t2_cmd_acks got %0d exp 1", cmd_acks - c0); else n_pass++;
    n_total++; if (dram_acks - d0 != 1) $display("FAIL t2_dram_acks got %0d exp 1", dram_acks - d0); else n_pass++;
    n_total++; if (bus.o_linear !== 16'h0013) $display("FAIL t2_commit got %h exp 0013", bus.o_linear); else n_pass++;
    pop_head();
  endtask

  task automatic test_pad_bcast();
    bit ok;
    int unsigned b0 = beat_n, c0 = cmd_acks, d0 = dram_acks;
    logic [DBW-1:0] base = 32'h3000_0000;
    logic [DBW*VSIZE-1:0] e = '0;
    for (int j = 0; j < 3; j++) e[j*DBW +: DBW] = 32'hDEAD_BEEF;
    for (int j = 3; j < 6; j++) e[j*DBW +: DBW] = base + 32'd5;
    do_alloc(16'h0020, 3'd3, 17'd6, 1'b0, 32'hDEAD_BEEF, ok);
    send_cmd(2'd2, 1'b0, 3'd0, 4'd3, 1'b0, '0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t3_pad_ack got %b exp 1", ok); else n_pass++;
    n_total++; if (dram_acks - d0 != 0) $display("FAIL t3_pad_dram got %0d exp 0", dram_acks - d0); else n_pass++;
    send_cmd(2'd1, 1'b1, 3'd5, 4'd3, 1'b1, mk_line(base), ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t3_bcast_ack got %b exp 1", ok); else n_pass++;
    tick(2);
    n_total++; if (beat_n - b0 != 1) $display("FAIL t3_beats got %0d exp 1", beat_n - b0); else n_pass++;
    n_total++; if ({mon_hi[b0], mon_mask[b0], mon_id[b0]} !== {13'd4, 8'h3F, 3'd3})
      $display("FAIL t3_beat got %h/%h/%0d exp 4/3f/3", mon_hi[b0], mon_mask[b0], mon_id[b0]); else n_pass++;
    n_total++; if ((mon_data[b0] & lanes(8'h3F)) !== e) $display("FAIL t3_data got %h exp %h", mon_data[b0] & lanes(8'h3F), e); else n_pass++;
    n_total++; if ({cmd_acks - c0, dram_acks - d0} !== {32'd2, 32'd1})
      $display("FAIL t3_acks got %0d/%0d exp 2/1", cmd_acks - c0, dram_acks - d0); else n_pass++;
    pop_head();
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    logic [DBW*CSIZE-1:0] ln = mk_line(32'h4000_0000);
    do_alloc(16'h0040, 3'd0, 17'd2, 1'b0, '0, ok);
    send_cmd(2'd0, 1'b1, 3'd0, 4'd2, 1'b1, ln, ok);
    do_alloc(16'h0050, 3'd1, 17'd2, 1'b0, '0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t4_second_alloc got %b exp 1", ok); else n_pass++;
    send_cmd(2'd0, 1'b1, 3'd0, 4'd2, 1'b1, ln, ok);
    tick(2);
    n_total++; if ({bus.done_linear_rdy, bus.o_linear} !== {1'b1, 16'h0040})
      $display("FAIL t4_head got %b/%h exp 1/0040", bus.done_linear_rdy, bus.o_linear); else n_pass++;
    bus.i_linear = 16'h0060; bus.i_linear_id = 3'd2; bus.i_size = 17'd2;
    bus.i_skip = 1'b0; bus.alloc_linear_rdy = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= bus.alloc_linear_ack; end
    n_total++; if (seen !== 1'b0) $display("FAIL t4_full_block got %b exp 0", seen); else n_pass++;
    @(posedge clk); #1;
    bus.done_linear_ack = 1'b1;
    @(negedge clk);
    n_total++; if (bus.alloc_linear_ack !== 1'b0) $display("FAIL t4_prepop got %b exp 0", bus.alloc_linear_ack); else n_pass++;
    @(posedge clk); #1;
    bus.done_linear_ack = 1'b0;
    @(negedge clk);
    n_total++; if (bus.alloc_linear_ack !== 1'b1) $display("FAIL t4_postpop got %b exp 1", bus.alloc_linear_ack); else n_pass++;
    n_total++; if (bus.o_linear !== 16'h0050) $display("FAIL t4_head2 got %h exp 0050", bus.o_linear); else n_pass++;
    @(posedge clk); #1;
    bus.alloc_linear_rdy = 1'b0;
    send_cmd(2'd0, 1'b1, 3'd0, 4'd2, 1'b1, ln, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t4_third_cmd got %b exp 1", ok); else n_pass++;
    tick(2);
    pop_head();
    n_total++; if ({bus.done_linear_rdy, bus.o_linear, bus.o_linear_id} !== {1'b1, 16'h0060, 3'd2})
      $display("FAIL t4_head3 got %b/%h/%0d exp 1/0060/2", bus.done_linear_rdy, bus.o_linear, bus.o_linear_id); else n_pass++;
    pop_head();
    n_total++; if (bus.done_linear_rdy !== 1'b0) $display("FAIL t4_empty got %b exp 0", bus.done_linear_rdy); else n_pass++;
  endtask

  task automatic test_skip();
    bit ok, seen;
    int unsigned b0 = beat_n;
    do_alloc(16'h0070, 3'd3, 17'd0, 1'b1, '0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t5_skip_ack got %b exp 1", ok); else n_pass++;
    n_total++; if ({bus.done_linear_rdy, bus.o_linear, bus.o_linear_id} !== {1'b1, 16'h0070, 3'd3})
      $display("FAIL t5_entry got %b/%h/%0d exp 1/0070/3", bus.done_linear_rdy, bus.o_linear, bus.o_linear_id); else n_pass++;
    do_alloc(16'h0074, 3'd2, 17'd0, 1'b1, '0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t5_skip2_ack got %b exp 1", ok); else n_pass++;
    bus.i_linear = 16'h0078; bus.i_linear_id = 3'd1; bus.i_skip = 1'b1; bus.alloc_linear_rdy = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= bus.alloc_linear_ack; end
    @(posedge clk); #1;
    bus.alloc_linear_rdy = 1'b0; bus.i_skip = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL t5_full_skip got %b exp 0", seen); else n_pass++;
    tick(2);
    n_total++; if (beat_n - b0 != 0) $display("FAIL t5_no_beat got %0d exp 0", beat_n - b0); else n_pass++;
    pop_head();
    n_total++; if ({bus.o_linear, bus.o_linear_id} !== {16'h0074, 3'd2})
      $display("FAIL t5_head2 got %h/%0d exp 0074/2", bus.o_linear, bus.o_linear_id); else n_pass++;
    pop_head();
    n_total++; if (bus.done_linear_rdy !== 1'b0) $display("FAIL t5_empty got %b exp 0", bus.done_linear_rdy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int unsigned b0 = beat_n;
    logic [DBW*CSIZE-1:0] ln = mk_line(32'h6000_0000);
    do_alloc(16'h0080, 3'd1, 17'd8, 1'b0, '0, ok);
    bus.i_cmd_type = 2'd0; bus.i_cmd_islast = 1'b0; bus.i_cmd_addrofs = 3'd0;
    bus.i_cmd_len = 4'd3; bus.i_dramrd = ln; bus.dramrd_rdy = 1'b1; bus.cmd_rdy = 1'b1;
    @(negedge clk);
    n_total++; if (bus.cmd_ack !== 1'b1) $display("FAIL t6_partial_step got %b exp 1", bus.cmd_ack); else n_pass++;
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if ({bus.w_dval, bus.done_linear_rdy, bus.o_wmask, bus.o_hiaddr, bus.o_id} !== '0)
      $display("FAIL t6_rst_ctl got %b/%b/%h/%h/%0d exp 0", bus.w_dval, bus.done_linear_rdy, bus.o_wmask, bus.o_hiaddr, bus.o_id); else n_pass++;
    n_total++; if ({bus.o_data, bus.o_linear, bus.o_linear_id} !== '0)
      $display("FAIL t6_rst_data got %h/%h/%0d exp 0", bus.o_data, bus.o_linear, bus.o_linear_id); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    n_total++; if (beat_n - b0 != 0) $display("FAIL t6_no_beat got %0d exp 0", beat_n - b0); else n_pass++;
    do_alloc(16'h0090, 3'd2, 17'd8, 1'b0, '0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL t6_fresh_alloc got %b exp 1", ok); else n_pass++;
    send_cmd(2'd0, 1'b1, 3'd0, 4'd8, 1'b1, ln, ok);
    tick(2);
    n_total++; if (beat_n - b0 != 1) $display("FAIL t6_beats got %0d exp 1", beat_n - b0); else n_pass++;
    n_total++; if ({mon_hi[b0], mon_mask[b0], mon_id[b0]} !== {13'h12, 8'hFF, 3'd2})
      $display("FAIL t6_beat got %h/%h/%0d exp 12/ff/2", mon_hi[b0], mon_mask[b0], mon_id[b0]); else n_pass++;
    n_total++; if (mon_data[b0] !== ln) $display("FAIL t6_data got %h exp %h", mon_data[b0], ln); else n_pass++;
    n_total++; if ({bus.done_linear_rdy, bus.o_linear} !== {1'b1, 16'h0090})
      $display("FAIL t6_commit got %b/%h exp 1/0090", bus.done_linear_rdy, bus.o_linear); else n_pass++;
    pop_head();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_pad_bcast();
    test_backpressure();
    test_skip();
    test_reset_mid_run();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sram_write_collector_q.md
Name: sram_write_collector_q

Overview:
- Successor collector for the TileAccumUnit read pipeline. Assembles DRAM cache-line reads and pad/broadcast commands into VSIZE-wide SRAM write beats for one linear buffer at a time.
- Adds an N_SLOT-deep commit queue, so a new linear allocation can be collected while earlier ones wait for downstream commit.
- Emits a per-lane write mask with every beat and flushes partial vectors at end of buffer.

Parameters:
LBW, 16, local SRAM address width (words)
DBW, 32, data word width
VSIZE, 8, words per SRAM write beat (power of 2, ≥2)
CSIZE, 8, words per DRAM read line (power of 2, ≥2)
N_ICFG, 4, number of input configs; ICFG_BW=$clog2(N_ICFG+1)
N_SLOT, 2, commit-queue depth (≥1)
Derived: CV_BW=$clog2(VSIZE), CV_BW1=$clog2(VSIZE+1), CC_BW=$clog2(CSIZE)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
alloc_linear_rdy/ack  in/out  1/1  new linear buffer request
i_linear  in  LBW  buffer start address
i_linear_id  in  ICFG_BW  config id
i_size  in  LBW+1  words to fill (≥1 unless skip)
i_skip  in  1  commit without filling
i_padv  in  DBW  pad value
cmd_rdy/ack  in/out  1/1  command stream
i_cmd_type  in  2  0 copy, 1 broadcast word, 2/3 pad
i_cmd_islast  in  1  last command consuming current DRAM line
i_cmd_addrofs  in  CC_BW  start word in DRAM line
i_cmd_len  in  CV_BW1  words, 1..VSIZE
dramrd_rdy/ack  in/out  1/1  DRAM line
i_dramrd  in  DBW×CSIZE  line data
done_linear_rdy/ack  out/in  1/1  commit queue head
o_linear  out  LBW  head address
o_linear_id  out  ICFG_BW  head id
w_dval  out  1  write beat valid
o_id  out  ICFG_BW  id of beat
o_hiaddr  out  LBW-CV_BW  beat address (word addr >> CV_BW)
o_wmask  out  VSIZE  lanes written
o_data  out  DBW×VSIZE  beat data

Behaviour:
- Handshakes: rdy/ack; transfer when both high in a cycle; ack only asserted with rdy.
- FSM {FREE, RUN}.
- reserved = queue occupancy + (fsm==RUN).
- FREE: alloc_linear_ack = alloc_linear_rdy && reserved<N_SLOT. On ack, latch linear/id/size/padv; cur=i_linear; filled=0; clear beat mask.
  - i_skip=1: push (linear,id) directly to queue, stay FREE, no w beat.
  - else go RUN.
- RUN step enable: cmd_rdy && (type∈{2,3} && !islast || dramrd_rdy).
- Per step:
  - lane=cur[CV_BW-1:0]; buf_left=VSIZE-lane; cmd_left=len-handled; adv=min(cmd_left,buf_left).
  - Lanes lane..lane+adv-1 are written and ORed into the beat mask.
  - Data: type0 word i_dramrd[addrofs+handled+k] for k<adv; type1 all lanes i_dramrd[addrofs+handled]; pad i_padv.
  - Line index arithmetic is mod CSIZE; the command never crosses a line.
  - cur+=adv (LBW wrap); filled+=adv.
  - cmd_ack when cmd_left≤buf_left, then handled=0; else handled+=adv.
  - dramrd_ack = cmd_ack && islast && dramrd_rdy.
- Beat emission, registered, 1 cycle after the step: w_dval=1 when that step fills lane VSIZE-1 or filled reaches size.
  - o_hiaddr = cur before step >> CV_BW; o_wmask = accumulated mask, which then clears; o_data lanes outside mask keep previous values.
- filled==size: push to queue same edge, return FREE.
  - The queue push never overflows because of the reservation rule.
- Queue: FIFO of N_SLOT entries. done_linear_rdy = !empty; o_linear/o_linear_id show head.
  - Push and pop in the same cycle allowed at any occupancy, including full.
- Simultaneous events: a FREE→RUN alloc and a pop in the same cycle use the pre-pop reserved count; the freed slot is usable next cycle.
- Reset (async, any state): FSM=FREE, queue empty, all outputs 0 (w_dval, o_wmask, o_data, o_hiaddr, o_id, o_linear, o_linear_id, all acks). No partial beat is emitted.
- Latency: first beat w_dval ≥2 cycles after alloc ack. Queue push in same cycle as final step; done_linear_rdy next cycle.

Test Plan:
1. VSIZE=8, CSIZE=8, alloc linear=0x10, size=8, one copy cmd addrofs=0 len=8 islast, line=0..7 → one beat hiaddr=2, wmask=0xFF, data 0..7; done_linear_rdy with o_linear=0x10.
2. Unaligned: linear=0x13, size=8, copy len=8 addrofs=2 → beat1 hiaddr=2 mask=0xF8 data lanes3-7 = words2-6; beat2 hiaddr=3 mask=0x07 = words7,0,1; cmd acked on step 2, dram acked once.
3. Pad + broadcast: size=6, pad len=3 (no dram), broadcast len=3 addrofs=5 islast → one beat mask=0x3F, lanes0-2=padv, lanes3-5=word5.
4. Queue backpressure, N_SLOT=2: complete two linears with done_linear_ack held low → third alloc_linear_ack stays 0; ack one commit → alloc accepted the cycle after.
5. Skip: alloc i_skip=1 id=3 → no w_dval, queue entry id=3; skip while queue full → not acked.
6. Reset mid-RUN after one partial step → no w_dval, queue empty, all outputs 0; a fresh alloc then completes normally.
